decode_s1_out_buffer: RTL

DECODE_S1_OUT_BUFFER -- requirements
Module: decode_s1_out_buffer

---
 rtl/decode_s1_out_buffer_pkg.sv | 44 ++++
 rtl/decode_buf_entry.sv | 21 ++
 rtl/decode_s1_out_buffer.sv | 98 +++++++++
 3 files changed

// File: rtl/decode_s1_out_buffer_pkg.sv
// Shared stage-1 decode definitions: bundle layout, field widths and the
// PC field offset used to pack s1_payload.
package decode_s1_out_buffer_pkg;

    localparam int unsigned IADDR_W     = 32;
    localparam int unsigned SIZE_W      = 4;
    localparam int unsigned OP_W        = 4;
    localparam int unsigned OPREG_W     = 3;
    localparam int unsigned MODRM_W     = 8;
    localparam int unsigned SIB_W       = 8;
    localparam int unsigned IMM_W       = 48;
    localparam int unsigned DISP_W      = 32;
    localparam int unsigned ALU_OP_W    = 5;
    localparam int unsigned STACK_OP_W  = 2;
    localparam int unsigned SEG_W       = 3;

    // Fields listed MSB first; branch_taken occupies bit 0 and pc sits just above it.
    typedef struct packed {
        logic [SIZE_W-1:0]     size;
        logic                  d_set;
        logic                  d_clear;
        logic [OP_W-1:0]       op0;
        logic [OP_W-1:0]       op1;
        logic [OPREG_W-1:0]    op0_reg;
        logic [OPREG_W-1:0]    op1_reg;
        logic [MODRM_W-1:0]    modrm;
        logic [SIB_W-1:0]      sib;
        logic [IMM_W-1:0]      imm;
        logic [DISP_W-1:0]     disp;
        logic [ALU_OP_W-1:0]   alu_op;
        logic                  flag_0;
        logic                  flag_1;
        logic [STACK_OP_W-1:0] stack_op;
        logic [SEG_W-1:0]      seg_override;
        logic                  seg_override_valid;
        logic                  movs;
        logic [IADDR_W-1:0]    pc;
        logic                  branch_taken;
    } decode_bundle_t;

    localparam int unsigned BUNDLE_W = $bits(decode_bundle_t);
    localparam int unsigned PC_LSB   = 1;

endpackage

// File: rtl/decode_buf_entry.sv
// One payload slot of the stage-1 output buffer: enabled register, no reset.
module decode_buf_entry #(
    parameter int unsigned WIDTH = 163
) (
    input  logic             clk,
    input  logic             en_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] data_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            data_q <= d_i;
        end
    end

    assign q_o = data_q;

endmodule

// File: rtl/decode_s1_out_buffer.sv
// Two-entry skid buffer between decode stage 1 and stage 2; every output is a
// function of registered state only, so s1_ready never sees same-cycle s2_ready.
module decode_s1_out_buffer
    import decode_s1_out_buffer_pkg::*;
#(
    parameter int unsigned WIDTH  = BUNDLE_W,
    parameter int unsigned IADDRW = IADDR_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             flush,
    input  logic             s1_valid,
    output logic             s1_ready,
    input  logic [WIDTH-1:0] s1_payload,
    output logic             s2_valid,
    input  logic             s2_ready,
    output logic [WIDTH-1:0] s2_payload,
    output logic [1:0]       occupancy,
    output logic             busy
);

    localparam int unsigned DEPTH = 2;
    localparam logic [1:0]  FULL  = 2'd2;

    if (WIDTH < PC_LSB + IADDRW) begin : g_bad_cfg
        $error("decode_s1_out_buffer: WIDTH too small to hold the PC field");
    end

    logic [1:0]       count_q, count_d;
    logic             wr_ptr_q, wr_ptr_d;
    logic             rd_ptr_q, rd_ptr_d;
    logic             push_c, pop_c;
    logic [DEPTH-1:0] wr_en_c;
    logic [WIDTH-1:0] entry_q [DEPTH];

    assign s1_ready   = (count_q != FULL);
    assign s2_valid   = (count_q != 2'd0);
    assign occupancy  = count_q;
    assign busy       = (count_q != 2'd0);
    assign s2_payload = entry_q[rd_ptr_q];

    // Pointer/count update; flush wins over any same-cycle push or pop.
    always_comb begin
        push_c   = s1_valid & s1_ready & ~flush;
        pop_c    = s2_valid & s2_ready & ~flush;
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (flush) begin
            count_d  = 2'd0;
            wr_ptr_d = 1'b0;
            rd_ptr_d = 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr_d = ~wr_ptr_q;
            end
            if (pop_c) begin
                rd_ptr_d = ~rd_ptr_q;
            end
            case ({push_c, pop_c})
                2'b10:   count_d = count_q + 2'd1;
                2'b01:   count_d = count_q - 2'd1;
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q  <= 2'd0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_comb begin
        wr_en_c = '0;
        for (int i = 0; i < DEPTH; i++) begin
            wr_en_c[i] = push_c & (wr_ptr_q == 1'(i));
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        decode_buf_entry #(
            .WIDTH (WIDTH)
        ) u_entry (
            .clk  (clk),
            .en_i (wr_en_c[g]),
            .d_i  (s1_payload),
            .q_o  (entry_q[g])
        );
    end

endmodule
